// File: rtl/add4.sv
// PC incrementer: combinational PC + 4 with wrap and alignment flags,
// plus an optional registered copy of the incremented PC.
module add4 #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] PC,
    input  logic             en,
    output logic [width-1:0] PCPlus4,
    output logic             Carry,
    output logic             Misaligned,
    output logic [width-1:0] PCPlus4_q,
    output logic             valid_q
);

    localparam logic [width:0] INCREMENT = (width+1)'(4);

    logic [width:0] sum;

    // One extra bit catches the wrap-around; it never reaches PCPlus4.
    assign sum        = {1'b0, PC} + INCREMENT;
    assign PCPlus4    = sum[width-1:0];
    assign Carry      = sum[width];
    assign Misaligned = (PC[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            PCPlus4_q <= '0;
            valid_q   <= 1'b0;
        end else if (en) begin
            PCPlus4_q <= PCPlus4;
            valid_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_add4.sv
// Self-checking bench for add4: combinational vector table, then
// hand-written reset / capture / hold sequences on the registered stage.
module tb_add4;

    logic        clk;
    logic        rst;
    logic [31:0] PC;
    logic        en;
    logic [31:0] PCPlus4;
    logic        Carry;
    logic        Misaligned;
    logic [31:0] PCPlus4_q;
    logic        valid_q;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] sum;
        logic        carry;
        logic        misaligned;
    } vector_t;

    vector_t vectors [10];

    add4 #(.width(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .PC         (PC),
        .en         (en),
        .PCPlus4    (PCPlus4),
        .Carry      (Carry),
        .Misaligned (Misaligned),
        .PCPlus4_q  (PCPlus4_q),
        .valid_q    (valid_q)
    );

    // Clock held low for the first 20 time units so the no-clock checks run first.
    initial begin
        clk = 1'b0;
        #20;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic rst_val, input logic en_val,
                                  input logic [31:0] pc_val);
        @(negedge clk);
        rst = rst_val;
        en  = en_val;
        PC  = pc_val;
    endtask

    task automatic check_comb(input string name, input logic [31:0] sum,
                              input logic carry, input logic misaligned);
        check_output({name, ".PCPlus4"}, PCPlus4, sum);
        check_output({name, ".Carry"}, {31'd0, Carry}, {31'd0, carry});
        check_output({name, ".Misaligned"}, {31'd0, Misaligned}, {31'd0, misaligned});
    endtask

    task automatic check_reg(input string name, input logic [31:0] q, input logic v);
        check_output({name, ".PCPlus4_q"}, PCPlus4_q, q);
        check_output({name, ".valid_q"}, {31'd0, valid_q}, {31'd0, v});
    endtask

    initial begin
        vectors[0] = '{32'h0000_0000, 32'h0000_0004, 1'b0, 1'b0};
        vectors[1] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 1'b0};
        vectors[2] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 1'b0, 1'b0};
        vectors[3] = '{32'h0000_1002, 32'h0000_1006, 1'b0, 1'b1};
        vectors[4] = '{32'hFFFF_FFFE, 32'h0000_0002, 1'b1, 1'b1};
        vectors[5] = '{32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0, 1'b1};
        vectors[6] = '{32'hFFFF_FFFD, 32'h0000_0001, 1'b1, 1'b1};
        vectors[7] = '{32'h0000_0001, 32'h0000_0005, 1'b0, 1'b1};
        vectors[8] = '{32'h7FFF_FFFC, 32'h8000_0000, 1'b0, 1'b0};
        vectors[9] = '{32'h1234_5678, 32'h1234_567C, 1'b0, 1'b0};

        rst = 1'b0;
        en  = 1'b0;
        PC  = 32'h0000_0000;

        #5;
        check_comb("no_clock_pc0", 32'h0000_0004, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            PC = vectors[i].pc;
            #1;
            check_comb($sformatf("vec%0d", i), vectors[i].sum,
                       vectors[i].carry, vectors[i].misaligned);
        end

        // Reset edge clears the registered stage.
        apply_stimulus(1'b1, 1'b0, 32'h0000_0050);
        @(posedge clk); #1;
        check_reg("after_reset", 32'h0, 1'b0);
        check_comb("during_reset", 32'h0000_0054, 1'b0, 1'b0);

        // Capture with one cycle of latency.
        apply_stimulus(1'b0, 1'b1, 32'h0000_0100);
        #1;
        check_reg("before_capture", 32'h0, 1'b0);
        @(posedge clk); #1;
        check_reg("capture_100", 32'h0000_0104, 1'b1);

        // Disabled: PC moves, only combinational outputs follow.
        apply_stimulus(1'b0, 1'b0, 32'h0000_0200);
        #1;
        check_comb("hold_comb", 32'h0000_0204, 1'b0, 1'b0);
        check_reg("hold_between_edges", 32'h0000_0104, 1'b1);
        @(posedge clk); #1;
        check_reg("hold_edge1", 32'h0000_0104, 1'b1);
        @(posedge clk); #1;
        check_reg("hold_edge2", 32'h0000_0104, 1'b1);

        // Reset wins over enable; combinational outputs are untouched.
        apply_stimulus(1'b1, 1'b1, 32'h0000_0200);
        #1;
        check_comb("rst_en_comb_pre", 32'h0000_0204, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_reg("rst_over_en", 32'h0, 1'b0);
        check_comb("rst_en_comb_post", 32'h0000_0204, 1'b0, 1'b0);

        // Wrapped value captured without its carry bit.
        apply_stimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        check_reg("capture_wrap", 32'h0000_0000, 1'b1);

        apply_stimulus(1'b0, 1'b1, 32'h0000_1002);
        #1;
        check_reg("pre_misaligned_capture", 32'h0000_0000, 1'b1);
        @(posedge clk); #1;
        check_reg("capture_misaligned", 32'h0000_1006, 1'b1);

        // Back-to-back enabled edges track PC each cycle.
        apply_stimulus(1'b0, 1'b1, 32'h0000_2000);
        @(posedge clk); #1;
        check_reg("stream0", 32'h0000_2004, 1'b1);
        apply_stimulus(1'b0, 1'b1, 32'h0000_3000);
        @(posedge clk); #1;
        check_reg("stream1", 32'h0000_3004, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/add4.md
ADD4 -- requirements
Module: add4

Interface
REQ-001 The module SHALL have parameter width, default 32, which sets the bit width of all address buses; supported range is width >= 3.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit, reset, synchronous and active-high.
REQ-004 The module SHALL have port PC, input, width bits, the current program counter.
REQ-005 The module SHALL have port en, input, 1 bit, the registered-stage capture enable.
REQ-006 The module SHALL have port PCPlus4, output, width bits, the combinational PC + 4.
REQ-007 The module SHALL have port Carry, output, 1 bit, combinational wrap-around flag of the PC + 4 addition.
REQ-008 The module SHALL have port Misaligned, output, 1 bit, combinational flag set when PC is not word-aligned.
REQ-009 The module SHALL have port PCPlus4_q, output, width bits, the registered copy of PCPlus4.
REQ-010 The module SHALL have port valid_q, output, 1 bit, set when PCPlus4_q holds a captured value.

Function
REQ-011 PCPlus4 SHALL equal (PC + 4) mod 2^width, purely combinational, with zero clock latency and no dependence on clk, rst or en.
REQ-012 PCPlus4 SHALL be valid even if clk is never toggled and rst is never asserted.
REQ-013 Carry SHALL be 1 exactly when PC >= 2^width - 4 (the addition wraps), else 0; combinational.
REQ-014 Misaligned SHALL equal (PC[1:0] != 2'b00); combinational; it SHALL NOT alter PCPlus4 (misaligned PCs are still incremented by exactly 4).
REQ-015 On a rising clk edge with rst = 0 and en = 1, PCPlus4_q SHALL load the current PCPlus4 value and valid_q SHALL become 1.
REQ-016 On a rising clk edge with rst = 0 and en = 0, PCPlus4_q and valid_q SHALL hold their values.
REQ-017 Registered-stage latency SHALL be exactly one clk cycle from PC/en sampling to PCPlus4_q update.
REQ-018 PC changes between clock edges SHALL affect only the combinational outputs until the next enabled edge.
REQ-019 All arithmetic SHALL be unsigned, width bits wide; the carry-out bit SHALL NOT appear in PCPlus4 or PCPlus4_q.

Reset
REQ-020 On a rising clk edge with rst = 1, PCPlus4_q SHALL become 0 and valid_q SHALL become 0, regardless of en.
REQ-021 rst SHALL take priority over en when both are asserted on the same edge.
REQ-022 rst SHALL have no effect on PCPlus4, Carry or Misaligned.
REQ-023 Before the first reset edge, PCPlus4_q and valid_q are undefined; no other output depends on them.

Verification
REQ-024 PC = 0x00000000, no clock, no reset -> within 10 time units PCPlus4 = 0x00000004, Carry = 0, Misaligned = 0.
REQ-025 PC = 0xFFFFFFFC -> PCPlus4 = 0x00000000, Carry = 1; PC = 0xFFFFFFF8 -> PCPlus4 = 0xFFFFFFFC, Carry = 0.
REQ-026 PC = 0x00001002 -> PCPlus4 = 0x00001006, Misaligned = 1.
REQ-027 rst = 1 for one edge, then en = 1, PC = 0x00000100 at next edge -> after that edge PCPlus4_q = 0x00000104, valid_q = 1; then en = 0, PC = 0x00000200 -> PCPlus4_q stays 0x00000104 while PCPlus4 = 0x00000204.
REQ-028 After capture of 0x00000104, assert rst = 1 with en = 1 on one edge -> PCPlus4_q = 0, valid_q = 0 after that edge; combinational outputs unchanged.
